// File: rtl/mem_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_fifo_ctrl_if
// Ready/valid handshake bundle between mem_fifo_ctrl and its producer/consumer.
//   enq_valid / enq_ready / enq_bits : producer pushes words into the FIFO
//   deq_valid / deq_ready / deq_bits : consumer pops the oldest word
// Modports:
//   master : the environment (drives enq_valid, enq_bits, deq_ready)
//   slave  : the FIFO controller (drives enq_ready, deq_valid, deq_bits)
// -----------------------------------------------------------------------------
interface mem_fifo_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fifo_ctrl
// FIFO controller wrapped around a 1R1W memory whose write enable is tied high.
// The memory is written every cycle at mem_waddr, so the controller always
// points the write at the free tail slot; an enqueue simply advances the tail
// past the word just written. Capacity is therefore DEPTH-1.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   flush         : synchronous clear of head/tail/count
//   fifo          : handshake interface (slave side)
//   count         : number of stored words, 0..DEPTH-1
//   mem_raddr     : memory read address (head), combinational read
//   mem_rdata     : memory read data, forwarded as deq_bits
//   mem_waddr     : memory write address (tail), written every cycle
//   mem_wdata     : memory write data (enq_bits)
// -----------------------------------------------------------------------------
module mem_fifo_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  mem_fifo_ctrl_if.slave    fifo,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  // One slot is sacrificed to absorb the unconditional memory write.
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] head_r;
  logic [ADDR_W-1:0] tail_r;
  logic [ADDR_W:0]   cnt_r;
  logic              enq_fire_s;
  logic              deq_fire_s;

  // Handshake, memory address and fire decodes straight from current state.
  always_comb begin
    fifo.enq_ready = 1'b0;
    fifo.deq_valid = 1'b0;
    if (cnt_r != FULL_CNT) begin
      fifo.enq_ready = 1'b1;
    end else begin
      fifo.enq_ready = 1'b0;
    end
    if (cnt_r != CNT_ZERO) begin
      fifo.deq_valid = 1'b1;
    end else begin
      fifo.deq_valid = 1'b0;
    end
    fifo.deq_bits = mem_rdata;
    mem_raddr     = head_r;
    mem_waddr     = tail_r;
    mem_wdata     = fifo.enq_bits;
    count         = cnt_r;
    enq_fire_s    = fifo.enq_valid & fifo.enq_ready;
    deq_fire_s    = fifo.deq_valid & fifo.deq_ready;
  end

  // Pointer and occupancy update; flush wins over any handshake that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
      cnt_r  <= CNT_ZERO;
    end else if (flush) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
      cnt_r  <= CNT_ZERO;
    end else begin
      // Pointers wrap naturally at ADDR_W bits.
      if (enq_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (deq_fire_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
module tb_mem_fifo_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;
  localparam int CAP    = DEPTH - 1;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  mem_fifo_ctrl_if #(.DATA_W(DATA_W)) fif ();

  mem_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .fifo      (fif),
    .count     (count),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Memory1R1W stand-in: always-write, combinational read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  // Reference model: a queue of stored words plus occupancy and pointer positions.
  logic [DATA_W-1:0] exp_q [$];
  int exp_cnt  = 0;
  int exp_head = 0;
  int exp_tail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare handshake/address outputs, then advance on the fires the model predicts.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        bit m_enq;
        bit m_deq;
        check("count",     64'(count),         64'(exp_cnt));
        check("enq_ready", 64'(fif.enq_ready), 64'(exp_cnt != CAP));
        check("deq_valid", 64'(fif.deq_valid), 64'(exp_cnt != 0));
        check("mem_waddr", 64'(mem_waddr),     64'(exp_tail));
        check("mem_raddr", 64'(mem_raddr),     64'(exp_head));
        check("mem_wdata", mem_wdata,          fif.enq_bits);
        m_enq = fif.enq_valid && (exp_cnt != CAP);
        m_deq = fif.deq_ready && (exp_cnt != 0);
        if (flush) begin
          exp_q.delete();
          exp_cnt  = 0;
          exp_head = 0;
          exp_tail = 0;
        end else begin
          if (m_enq) begin
            exp_q.push_back(fif.enq_bits);
            exp_tail = (exp_tail + 1) % DEPTH;
          end
          if (m_deq) exp_head = (exp_head + 1) % DEPTH;
          exp_cnt = exp_cnt + int'(m_enq) - int'(m_deq);
        end
      end
    end
  end

  // Monitor: whenever the DUT hands out a word, it must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && !flush && fif.deq_valid && fif.deq_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("deq_unexpected", fif.deq_bits, 64'hFFFF_FFFF_FFFF_FFFF ^ fif.deq_bits);
        end else begin
          check("deq_bits", fif.deq_bits, exp_q.pop_front());
        end
      end
    end
  end

  // Apply one cycle of inputs, returning 2 time units after the next rising edge.
  task automatic drive(input logic ev, input logic [63:0] eb, input logic dr, input logic fl);
    fif.enq_valid = ev;
    fif.enq_bits  = eb;
    fif.deq_ready = dr;
    flush         = fl;
    @(posedge clock);
    #2;
  endtask

  int base;

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    fif.enq_valid = 1'b0;
    fif.enq_bits  = 64'h0;
    fif.deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    check("rst_count",     64'(count),         64'd0);
    check("rst_enq_ready", 64'(fif.enq_ready), 64'd1);
    check("rst_deq_valid", 64'(fif.deq_valid), 64'd0);

    // T1: asynchronous reset mid-cycle with five words stored.
    for (int i = 0; i < 5; i++) drive(1'b1, 64'h50 + 64'(i), 1'b0, 1'b0);
    fif.enq_valid = 1'b0;
    check("t1_pre_count", 64'(count), 64'd5);
    #1 reset = 1'b1;
    #1;
    check("t1_count",     64'(count),         64'd0);
    check("t1_deq_valid", 64'(fif.deq_valid), 64'd0);
    check("t1_enq_ready", 64'(fif.enq_ready), 64'd1);
    check("t1_waddr",     64'(mem_waddr),     64'd0);
    check("t1_raddr",     64'(mem_raddr),     64'd0);
    exp_q.delete();
    exp_cnt  = 0;
    exp_head = 0;
    exp_tail = 0;
    @(posedge clock);
    #2 reset = 1'b0;

    // T2: fill to capacity; the 32nd offer is held.
    for (int i = 0; i < CAP; i++) drive(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h11F, 1'b0, 1'b0);
    check("t2_count",     64'(count),         64'd31);
    check("t2_enq_ready", 64'(fif.enq_ready), 64'd0);

    // T3: drain in order.
    base = n_pops;
    for (int i = 0; i < CAP + 2; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);
    check("t3_pops",      64'(n_pops - base), 64'd31);
    check("t3_count",     64'(count),         64'd0);
    check("t3_deq_valid", 64'(fif.deq_valid), 64'd0);

    // T4: streaming through several pointer wraps.
    base = n_pops;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      check("t4_count", 64'(count), 64'd1);
    end
    for (int i = 0; i < 2; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);
    check("t4_pops", 64'(n_pops - base), 64'd100);

    // T5: idle cycles rewrite the tail slot but never enqueue.
    base = n_pops;
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    drive(1'b1, 64'hC, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 64'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 64'hDEAD, 1'b1, 1'b0);
    check("t5_pops", 64'(n_pops - base), 64'd3);

    // T6: flush overrides simultaneous enqueue and dequeue.
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h60 + 64'(i), 1'b0, 1'b0);
    drive(1'b1, 64'h77, 1'b1, 1'b1);
    fif.enq_valid = 1'b0;
    fif.deq_ready = 1'b0;
    flush         = 1'b0;
    check("t6_count",     64'(count),         64'd0);
    check("t6_deq_valid", 64'(fif.deq_valid), 64'd0);
    check("t6_waddr",     64'(mem_waddr),     64'd0);
    check("t6_raddr",     64'(mem_raddr),     64'd0);

    // T7: full with dequeue; ready only returns the cycle after.
    for (int i = 0; i < CAP; i++) drive(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
    drive(1'b1, 64'h999, 1'b1, 1'b0);
    check("t7_c1_count", 64'(count),         64'd30);
    check("t7_c1_ready", 64'(fif.enq_ready), 64'd1);
    drive(1'b1, 64'h999, 1'b1, 1'b0);
    check("t7_c2_count", 64'(count), 64'd30);
    for (int i = 0; i < CAP + 2; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);

    // Random traffic; offered words are held while not accepted.
    for (int i = 0; i < 600; i++) begin
      logic        ev;
      logic [63:0] eb;
      if (fif.enq_valid && !fif.enq_ready) begin
        ev = 1'b1;
        eb = fif.enq_bits;
      end else begin
        ev = ($urandom_range(99) < 60);
        eb = {$urandom, $urandom};
      end
      drive(ev, eb, ($urandom_range(99) < ((i / 150) % 2 == 0 ? 70 : 35)),
            ($urandom_range(199) == 0));
    end
    for (int i = 0; i < CAP + 2; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);
    check("final_q",     64'(exp_q.size()), 64'd0);
    check("final_count", 64'(count),        64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
